// File: rtl/vreg_write_arbiter_if.sv
// Writeback request bundle between the execution/load writeback units and
// the vector register file write arbiter. Each requester owns one slice of
// the flattened rd/data buses; hold freezes new grants.
interface vreg_write_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 256,
  parameter int ADDR_W = 5
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_rd;
  logic [NREQ*DATA_W-1:0] req_data;
  logic                   hold;

  // Writeback units drive requests and observe grants.
  modport master (
    output req_valid,
    output req_rd,
    output req_data,
    output hold,
    input  req_ready
  );

  // The arbiter observes requests and drives grants.
  modport slave (
    input  req_valid,
    input  req_rd,
    input  req_data,
    input  hold,
    output req_ready
  );
endinterface

// File: rtl/vreg_write_arbiter.sv
// vreg_write_arbiter: round-robin arbitration of NREQ writeback sources onto
// the single write port of the 32 x DATA_W vector register file.
// - The grant scan starts at ptr_q and wraps; ptr_q moves past the winner.
// - The winning write is registered onto WriteEn/rd/InputData/grant_id.
// - Accepted requests addressing a scalar register (rd < 16) are consumed
//   without a write and set the sticky err_addr flag.
// Optional feature macro: VREG_ARB_FORWARD_EN. When defined, the in-flight
// registered write is bypassed onto Rout1/Rout2; otherwise they pass RfOut
// through unchanged.
module vreg_write_arbiter #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 256,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vreg_write_arbiter_if.slave   req_if,
  output logic                  WriteEn,
  output logic [ADDR_W-1:0]     rd,
  output logic [DATA_W-1:0]     InputData,
  output logic [1:0]            grant_id,
  output logic                  err_addr,
  input  logic [ADDR_W-1:0]     Rs1,
  input  logic [ADDR_W-1:0]     Rs2,
  input  logic [DATA_W-1:0]     RfOut1,
  input  logic [DATA_W-1:0]     RfOut2,
  output logic [DATA_W-1:0]     Rout1,
  output logic [DATA_W-1:0]     Rout2
);

  // Registered state and its next-state values.
  logic [1:0]        ptr_q,  ptr_d;
  logic              we_q,   we_d;
  logic [ADDR_W-1:0] rd_q,   rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        gid_q,  gid_d;
  logic              err_q,  err_d;

  // Combinational arbitration results.
  logic [2:0]        cand_s;
  logic              grant_found_s;
  logic [1:0]        grant_idx_s;
  logic              xfer_s;
  logic [NREQ-1:0]   ready_s;
  logic [ADDR_W-1:0] sel_rd_s;
  logic [DATA_W-1:0] sel_data_s;

  // Scan requesters starting at the round-robin pointer; first valid one wins.
  always_comb begin
    cand_s        = 3'd0;
    grant_found_s = 1'b0;
    grant_idx_s   = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, ptr_q} + 3'(k);
      cand_s = (cand_s >= 3'(NREQ)) ? (cand_s - 3'(NREQ)) : cand_s;
      if (!grant_found_s && req_if.req_valid[cand_s[1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[1:0];
      end else begin
        grant_idx_s   = grant_idx_s;
      end
    end
  end

  // Gate the grant with hold and reset, and select the winner's payload.
  always_comb begin
    xfer_s     = grant_found_s && !req_if.hold && rst_n;
    ready_s    = {NREQ{1'b0}};
    sel_rd_s   = req_if.req_rd[grant_idx_s*ADDR_W +: ADDR_W];
    sel_data_s = req_if.req_data[grant_idx_s*DATA_W +: DATA_W];
    if (xfer_s) begin
      ready_s[grant_idx_s] = 1'b1;
    end else begin
      ready_s = {NREQ{1'b0}};
    end
  end

  assign req_if.req_ready = ready_s;

  // Next-state: advance pointer past the winner, register vector writes,
  // flag scalar-address writes; without a transfer only WriteEn drops.
  always_comb begin
    ptr_d  = ptr_q;
    we_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    gid_d  = gid_q;
    err_d  = err_q;
    if (xfer_s) begin
      ptr_d = (grant_idx_s == 2'(NREQ-1)) ? 2'd0 : (grant_idx_s + 2'd1);
      if (sel_rd_s[ADDR_W-1]) begin
        we_d   = 1'b1;
        rd_d   = sel_rd_s;
        data_d = sel_data_s;
        gid_d  = grant_idx_s;
      end else begin
        err_d  = 1'b1;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers; reset drops any pending write immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= 2'd0;
      we_q   <= 1'b0;
      rd_q   <= {ADDR_W{1'b0}};
      data_q <= {DATA_W{1'b0}};
      gid_q  <= 2'd0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      gid_q  <= gid_d;
      err_q  <= err_d;
    end
  end

  assign WriteEn   = we_q;
  assign rd        = rd_q;
  assign InputData = data_q;
  assign grant_id  = gid_q;
  assign err_addr  = err_q;

`ifdef VREG_ARB_FORWARD_EN
  // Bypass the write being committed this cycle to matching read ports.
  assign Rout1 = (we_q && (rd_q == Rs1)) ? data_q : RfOut1;
  assign Rout2 = (we_q && (rd_q == Rs2)) ? data_q : RfOut2;
`else
  // Plain passthrough: a committing write becomes visible one cycle later.
  // Read addresses only feed the register file itself in this build.
  logic unused_rs_s;
  assign unused_rs_s = ^{Rs1, Rs2};
  assign Rout1 = RfOut1;
  assign Rout2 = RfOut2;
`endif

endmodule

// File: tb/tb_vreg_write_arbiter.sv
// Directed self-checking bench for vreg_write_arbiter, with a simple
// 32-entry register file model fed by the arbiter's write port.
module tb_vreg_write_arbiter;
  localparam int NREQ   = 3;
  localparam int DATA_W = 256;
  localparam int ADDR_W = 5;

  logic clk;
  logic rst_n;
  logic              WriteEn;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] InputData;
  logic [1:0]        grant_id;
  logic              err_addr;
  logic [ADDR_W-1:0] Rs1, Rs2;
  logic [DATA_W-1:0] RfOut1, RfOut2, Rout1, Rout2;
  logic [DATA_W-1:0] rf_mem [32];

  int checks = 0;
  int errors = 0;

  vreg_write_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  vreg_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_if(bus.slave),
    .WriteEn(WriteEn), .rd(rd), .InputData(InputData), .grant_id(grant_id),
    .err_addr(err_addr), .Rs1(Rs1), .Rs2(Rs2), .RfOut1(RfOut1), .RfOut2(RfOut2),
    .Rout1(Rout1), .Rout2(Rout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: commits on the edge that ends a WriteEn cycle.
  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
  end
  always @(posedge clk) begin
    if (WriteEn) rf_mem[rd] <= InputData;
  end
  assign RfOut1 = rf_mem[Rs1];
  assign RfOut2 = rf_mem[Rs2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    bus.req_rd[i*ADDR_W +: ADDR_W]   = r;
    bus.req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_valid = 3'b111;
    #1;
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", bus.req_ready); end
    checks++; if (WriteEn !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", WriteEn); end
    checks++; if (rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d expected 0", rd); end
    checks++; if (InputData !== 256'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", InputData); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid: got %0d expected 0", grant_id); end
    checks++; if (err_addr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_addr); end
    #11;
    bus.req_valid = 3'b000;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    set_req(0, 5'd16, 256'd100);
    bus.req_valid = 3'b001;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL single_ready: got %b expected 001", bus.req_ready); end
    tick();
    bus.req_valid = 3'b000;
    checks++; if (WriteEn !== 1'b1) begin errors++; $display("FAIL single_we: got %b expected 1", WriteEn); end
    checks++; if (rd !== 5'd16) begin errors++; $display("FAIL single_rd: got %0d expected 16", rd); end
    checks++; if (InputData !== 256'd100) begin errors++; $display("FAIL single_data: got %0d expected 100", InputData); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_gid: got %0d expected 0", grant_id); end
    tick();
    checks++; if (WriteEn !== 1'b0) begin errors++; $display("FAIL single_we_drop: got %b expected 0", WriteEn); end
  endtask

  task automatic test_contention();
    logic [2:0] exp_ready;
    logic [1:0] exp_gid;
    pulse_reset();
    set_req(0, 5'd16, 256'd200);
    set_req(1, 5'd17, 256'd201);
    set_req(2, 5'd18, 256'd202);
    bus.req_valid = 3'b111;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_gid   = 2'(k % 3);
      exp_ready = 3'b001 << exp_gid;
      checks++; if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL contention_ready[%0d]: got %b expected %b", k, bus.req_ready, exp_ready); end
      tick();
      checks++; if (grant_id !== exp_gid) begin errors++; $display("FAIL contention_gid[%0d]: got %0d expected %0d", k, grant_id, exp_gid); end
      checks++; if (WriteEn !== 1'b1 || rd !== (5'd16 + 5'(exp_gid))) begin errors++; $display("FAIL contention_write[%0d]: got we=%b rd=%0d expected we=1 rd=%0d", k, WriteEn, rd, 16 + exp_gid); end
    end
    bus.req_valid = 3'b000;
    tick();
  endtask

  task automatic test_bad_address();
    set_req(1, 5'd3, 256'd77);
    bus.req_valid = 3'b010;
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL bad_ready: got %b expected 010", bus.req_ready); end
    tick();
    bus.req_valid = 3'b000;
    checks++; if (WriteEn !== 1'b0) begin errors++; $display("FAIL bad_we: got %b expected 0", WriteEn); end
    checks++; if (err_addr !== 1'b1) begin errors++; $display("FAIL bad_err_set: got %b expected 1", err_addr); end
    set_req(1, 5'd17, 256'd300);
    bus.req_valid = 3'b010;
    tick();
    bus.req_valid = 3'b000;
    checks++; if (WriteEn !== 1'b1 || InputData !== 256'd300) begin errors++; $display("FAIL bad_next_write: got we=%b data=%0d expected we=1 data=300", WriteEn, InputData); end
    tick();
    checks++; if (err_addr !== 1'b1) begin errors++; $display("FAIL bad_err_sticky: got %b expected 1", err_addr); end
  endtask

  task automatic test_hold();
    set_req(0, 5'd19, 256'd400);
    bus.req_valid = 3'b001;
    tick();
    bus.hold = 1'b1;
    set_req(1, 5'd20, 256'd500);
    bus.req_valid = 3'b010;
    #1;
    checks++; if (WriteEn !== 1'b1 || rd !== 5'd19) begin errors++; $display("FAIL hold_prior_write: got we=%b rd=%0d expected we=1 rd=19", WriteEn, rd); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL hold_ready[%0d]: got %b expected 000", k, bus.req_ready); end
      if (k < 2) tick();
    end
    checks++; if (WriteEn !== 1'b0) begin errors++; $display("FAIL hold_we: got %b expected 0", WriteEn); end
    bus.hold = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL hold_release_ready: got %b expected 010", bus.req_ready); end
    tick();
    bus.req_valid = 3'b000;
    checks++; if (WriteEn !== 1'b1 || grant_id !== 2'd1 || rd !== 5'd20) begin errors++; $display("FAIL hold_release_write: got we=%b gid=%0d rd=%0d expected we=1 gid=1 rd=20", WriteEn, grant_id, rd); end
    tick();
  endtask

  task automatic test_async_reset();
    set_req(0, 5'd21, 256'd600);
    set_req(1, 5'd22, 256'd601);
    set_req(2, 5'd23, 256'd602);
    bus.req_valid = 3'b010;
    tick();
    checks++; if (WriteEn !== 1'b1) begin errors++; $display("FAIL areset_pre_we: got %b expected 1", WriteEn); end
    bus.req_valid = 3'b111;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (WriteEn !== 1'b0) begin errors++; $display("FAIL areset_we: got %b expected 0", WriteEn); end
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL areset_ready: got %b expected 000", bus.req_ready); end
    checks++; if (err_addr !== 1'b0) begin errors++; $display("FAIL areset_err: got %b expected 0", err_addr); end
    #1;
    rst_n = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL areset_first_ready: got %b expected 001", bus.req_ready); end
    tick();
    bus.req_valid = 3'b000;
    checks++; if (WriteEn !== 1'b1 || grant_id !== 2'd0 || rd !== 5'd21) begin errors++; $display("FAIL areset_first_grant: got we=%b gid=%0d rd=%0d expected we=1 gid=0 rd=21", WriteEn, grant_id, rd); end
    tick();
  endtask

  task automatic test_forwarding();
    logic [DATA_W-1:0] exp_commit;
    Rs1 = 5'd18;
    Rs2 = 5'd18;
    set_req(2, 5'd18, 256'h1111);
    bus.req_valid = 3'b100;
    tick();
    bus.req_valid = 3'b000;
    tick();
    checks++; if (Rout1 !== 256'h1111) begin errors++; $display("FAIL fwd_prior: got %h expected 1111", Rout1); end
    set_req(2, 5'd18, 256'hABCD);
    bus.req_valid = 3'b100;
    tick();
    bus.req_valid = 3'b000;
`ifdef VREG_ARB_FORWARD_EN
    exp_commit = 256'hABCD;
`else
    exp_commit = 256'h1111;
`endif
    checks++; if (WriteEn !== 1'b1) begin errors++; $display("FAIL fwd_we: got %b expected 1", WriteEn); end
    checks++; if (Rout1 !== exp_commit) begin errors++; $display("FAIL fwd_commit_rout1: got %h expected %h", Rout1, exp_commit); end
    checks++; if (Rout2 !== exp_commit) begin errors++; $display("FAIL fwd_commit_rout2: got %h expected %h", Rout2, exp_commit); end
    Rs2 = 5'd16;
    #1;
    checks++; if (Rout2 !== 256'd200) begin errors++; $display("FAIL fwd_other_reg: got %h expected %h", Rout2, 256'd200); end
    tick();
    checks++; if (Rout1 !== 256'hABCD) begin errors++; $display("FAIL fwd_after_commit: got %h expected abcd", Rout1); end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 3'b000;
    bus.req_rd    = '0;
    bus.req_data  = '0;
    bus.hold      = 1'b0;
    Rs1           = 5'd0;
    Rs2           = 5'd0;
    test_reset();
    test_single_write();
    test_contention();
    test_bad_address();
    test_hold();
    test_async_reset();
    test_forwarding();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vreg_write_arbiter.md
# vreg_write_arbiter

- Shares the single write port of the 32×256-bit vector register file among NREQ writeback sources using a round-robin valid/ready handshake.
- Registers the winning write onto the file's WriteEn/rd/InputData port.
- Flags writes that target non-vector addresses.
- Optionally forwards the in-flight write to the file's two read ports.
- Sits between the execution/load writeback units and the vector register file.

## Interface
Parameters:
- NREQ, 3, number of write requesters (2..4)
- DATA_W, 256, vector data width
- ADDR_W, 5, register address width; vector registers are addresses 16..31

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester write request
- req_ready  out  NREQ  per-requester grant, combinational
- req_rd  in  NREQ*ADDR_W  destination address; requester i uses slice [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  write data; requester i uses slice [i*DATA_W +: DATA_W]
- hold  in  1  when 1, no new grants
- WriteEn  out  1  register-file write enable (registered)
- rd  out  ADDR_W  register-file write address (registered)
- InputData  out  DATA_W  register-file write data (registered)
- grant_id  out  2  index of the requester that produced the current WriteEn (registered)
- err_addr  out  1  sticky flag; set when a request with rd < 16 is accepted
- Rs1, Rs2  in  ADDR_W  read addresses, also driven to the register file
- RfOut1, RfOut2  in  DATA_W  raw register-file read data
- Rout1, Rout2  out  DATA_W  read data delivered to consumers

## Operation
- **Round-robin pointer `ptr`** (0..NREQ-1, reset 0):
  - The grant goes to the first i with req_valid[i]=1, scanning ptr, ptr+1, …, wrapping modulo NREQ.
  - At most one req_ready bit is high per cycle.
  - When hold=1 or rst_n=0, all req_ready bits are 0.
- **Handshake:**
  - A transfer occurs on a rising edge where req_valid[i] && req_ready[i].
  - A requester keeps req_rd/req_data stable and req_valid high until its transfer.
  - Dropping valid before the transfer is allowed (the request is withdrawn, nothing is written).
- **On transfer from requester g:** `ptr` ← (g+1) mod NREQ.
  - If req_rd[g][4]=1: next cycle WriteEn=1, rd=req_rd[g], InputData=req_data[g], grant_id=g.
  - If req_rd[g][4]=0: the request is consumed (ready was high), WriteEn stays 0 next cycle, and err_addr←1.
- **With no transfer:** WriteEn←0. rd, InputData and grant_id hold their last values.
- **Throughput:** one write per cycle. Back-to-back grants to different requesters are allowed. A single always-valid requester is re-granted every cycle only if no other requester is valid.
- **err_addr:** cleared only by reset.

## Timing
- **Reset values** (asynchronous on rst_n=0): WriteEn=0, rd=0, InputData=0, grant_id=0, err_addr=0, ptr=0. req_ready=0 while rst_n=0.
- **Reset mid-operation:** a pending registered write is dropped (WriteEn falls immediately, not at the clock edge).
- **Latency:**
  - Transfer at edge N gives WriteEn=1 during cycle N..N+1.
  - The register file commits at edge N+1.
  - Data is readable from RfOut at cycle N+1.
- **hold** acts combinationally on req_ready. A write already registered still issues while hold=1.
- **Simultaneous valid from all requesters:** grants rotate strictly, e.g. 0,1,2,0,… from reset.
- **Pointer wrap:** a grant to NREQ-1 sets ptr=0.

## Configuration
- **Macro `VREG_ARB_FORWARD_EN`.**
- **Defined:**
  - Rout1 = (WriteEn && rd==Rs1) ? InputData : RfOut1.
  - Rout2 likewise with Rs2.
  - A read in the commit cycle returns the value being written.
- **Undefined:**
  - Rout1=RfOut1 and Rout2=RfOut2 (pure passthrough).
  - A read in the commit cycle returns the old register value.
  - The new value is visible one cycle later.

## Test plan
- **Reset, then single write.** req_valid=3'b001, req_rd[0]=16, data=256'd100 → req_ready=3'b001. Next cycle WriteEn=1, rd=16, InputData=100, grant_id=0. One cycle later WriteEn=0.
- **Full contention.** req_valid=3'b111 held for 6 cycles, distinct rd 16/17/18 → grant_id sequence 0,1,2,0,1,2 and exactly one req_ready bit per cycle.
- **Bad address.** Requester 1 with rd=5'd3 → req_ready[1]=1, no WriteEn pulse, err_addr=1 and stays 1 after later valid writes.
- **Hold.** hold=1 for 3 cycles with req_valid=3'b010 → req_ready=0 throughout. A write registered before hold still pulses WriteEn once. After hold=0 the grant goes to 1 within one cycle.
- **Async reset mid-write.**
  - Step: rst_n low between edges while WriteEn=1 → WriteEn=0 immediately.
  - After release, the first grant with req_valid=3'b111 goes to requester 0.
- **Forwarding** (both builds). Write rd=18, data=256'hABCD with Rs1=18 during the commit cycle.
  - VREG_ARB_FORWARD_EN defined → Rout1=256'hABCD.
  - Undefined → Rout1 equals the prior RfOut1 value.
